nibble_ser_tx: RTL and testbench
================================

NIBBLE_SER_TX -- requirements
Module: nibble_ser_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (legal range 1..255).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit 3 first, 0 sends bit 0 first.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream nibble available.
REQ-006 SHALL have port in_data  input  4  parallel nibble from the upstream load register.
REQ-007 SHALL have port in_ready  output  1  block can accept a nibble this cycle.
REQ-008 SHALL have port ser_out  output  1  serial line; idles high.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse in the final cycle of a frame.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, (PARITY), STOP.
REQ-012 SHALL drive in_ready = 1 only in IDLE with rst low; it is 0 in every other state.
REQ-013 SHALL capture in_data into an internal shift register on the edge where in_valid && in_ready, and move IDLE->START on that edge.
REQ-014 SHALL ignore changes to in_data after capture, and ignore in_valid outside IDLE.
REQ-015 SHALL hold each bit on ser_out for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-016 SHALL drive ser_out = 0 in START, the data bits in MSB_FIRST order in DATA (2-bit index, 4 bits), and ser_out = 1 in STOP and IDLE.
REQ-017 SHALL go DATA->STOP after the 4th bit, or DATA->PARITY when parity is compiled in; PARITY->STOP; and STOP->IDLE after its last cycle.
REQ-018 SHALL assert done for exactly one cycle: the last cycle of STOP.
REQ-019 SHALL assert busy in every non-IDLE state.
REQ-020 SHALL make the frame 6*CLKS_PER_BIT cycles long, or 7*CLKS_PER_BIT with parity.
REQ-021 SHALL leave at least one IDLE cycle between back-to-back frames, so the next accept occurs 1 cycle after done.
REQ-022 SHALL work with CLKS_PER_BIT = 1, giving one cycle per bit.

Reset
REQ-023 SHALL, on any edge with rst high, go to IDLE and set ser_out = 1, busy = 0, done = 0, shift register = 0, counters = 0.
REQ-024 SHALL, when reset is asserted mid-frame, abort the frame on the next edge with no done pulse; the nibble is discarded.
REQ-025 SHALL take rst priority over a simultaneous handshake.

Configuration
REQ-026 SHALL, with macro NIBBLE_SER_PARITY_EN defined, insert one even-parity bit (XOR of the 4 data bits) between DATA and STOP.
REQ-027 SHALL, without NIBBLE_SER_PARITY_EN, omit the PARITY state and its logic entirely.

Structure
REQ-028 SHALL take from package nibble_ser_pkg: the state enum type, DATA_BITS = 4, and IDLE_LEVEL = 1'b1.
REQ-029 SHALL instantiate one sub-module, bit_tick_gen, which counts CLKS_PER_BIT and emits a bit_end pulse; it is cleared by rst and by a frame start.

Verification
REQ-030 SHALL cover: CLKS_PER_BIT = 4, MSB_FIRST = 1, send 4'hA -> ser_out 0,1,0,1,0,1 with each bit 4 cycles; done 24 cycles after accept; busy high for 24 cycles.
REQ-031 SHALL cover: in_valid held high with 4'hC then 4'hF queued -> frames 0,1,1,0,0,1 then 0,1,1,1,1,1; second accept 1 cycle after first done.
REQ-032 SHALL cover: accept 4'hC, then change in_data to 4'h2 the next cycle -> serial data is still 1100.
REQ-033 SHALL cover: rst pulsed during the 2nd DATA bit -> next edge ser_out = 1, busy = 0; no done; in_ready = 1 the cycle after rst falls.
REQ-034 SHALL cover: NIBBLE_SER_PARITY_EN defined, send 4'hA -> parity bit 0; send 4'h7 -> parity bit 1; frame 28 cycles.
REQ-035 SHALL cover: CLKS_PER_BIT = 1, MSB_FIRST = 0, send 4'h1 -> ser_out 0,1,0,0,0,1 on consecutive cycles.

Source files
------------

// File: rtl/nibble_ser_pkg.sv
// Shared types and constants for the nibble serializer.
// Build option: NIBBLE_SER_PARITY_EN adds an even-parity bit state.
package nibble_ser_pkg;

  localparam int   DATA_BITS  = 4;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef NIBBLE_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

endpackage

// File: rtl/nibble_ser_if.sv
// Upstream load handshake and serial-side status of the nibble serializer.
// Handshake: a nibble moves on a rising edge where in_valid && in_ready; in_data must be stable in that cycle only.
interface nibble_ser_if;
  import nibble_ser_pkg::*;

  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;
  logic                 ser_out;
  logic                 busy;
  logic                 done;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, busy, done
  );

endinterface

// File: rtl/nibble_ser_tx_bit_tick_gen.sv
// Bit-period down-counter: bit_end pulses in the last cycle of every serial bit.
// Held at zero outside a frame; reloaded when a frame starts and at each bit boundary.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic bit_end
);

  localparam logic [7:0] RELOAD = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= RELOAD;
    end else if (!active) begin
      cnt <= 8'd0;
    end else if (cnt == 8'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign bit_end = active && (cnt == 8'd0);

endmodule

// File: rtl/nibble_ser_tx.sv
// Nibble serializer: start bit (0), 4 data bits, optional even parity, stop bit (1).
// Build option: NIBBLE_SER_PARITY_EN inserts the parity bit between DATA and STOP.
module nibble_ser_tx
  import nibble_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic        clk,
  input  logic        rst,
  nibble_ser_if.slave bus,
  output state_t      dbg_state
);

  state_t               state;
  state_t               state_next;
  logic [DATA_BITS-1:0] sh;
  logic [1:0]           idx;
  logic                 accept;
  logic                 bit_end;
  logic                 ser_level;
`ifdef NIBBLE_SER_PARITY_EN
  logic                 par;
`endif

  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .active (state != IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      idx   <= 2'd0;
`ifdef NIBBLE_SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        sh  <= bus.in_data;
        idx <= 2'd0;
`ifdef NIBBLE_SER_PARITY_EN
        par <= ^bus.in_data;
`endif
      end else if ((state == DATA) && bit_end) begin
        // The bit on the wire is always at one end of sh, so shift it away.
        if (MSB_FIRST != 0) sh <= {sh[DATA_BITS-2:0], 1'b0};
        else                sh <= {1'b0, sh[DATA_BITS-1:1]};
        idx <= idx + 2'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    ser_level  = IDLE_LEVEL;
    unique case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        ser_level = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        ser_level = (MSB_FIRST != 0) ? sh[DATA_BITS-1] : sh[0];
`ifdef NIBBLE_SER_PARITY_EN
        if (bit_end && (idx == 2'd3)) state_next = PARITY;
      end
      PARITY: begin
        ser_level = par;
        if (bit_end) state_next = STOP;
`else
        if (bit_end && (idx == 2'd3)) state_next = STOP;
`endif
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ser_out = ser_level;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == STOP) && bit_end;
  assign dbg_state   = state;

endmodule

// File: tb/tb_nibble_ser_tx.sv
// Self-checking bench for nibble_ser_tx: table vectors, random nibbles against a frame model, reset corners.
// Two instances: CLKS_PER_BIT=4/MSB first, and CLKS_PER_BIT=1/LSB first.
module tb_nibble_ser_tx;
  import nibble_ser_pkg::*;

  localparam int CPB = 4;
`ifdef NIBBLE_SER_PARITY_EN
  localparam int NBITS = 7;
`else
  localparam int NBITS = 6;
`endif
  localparam int FLEN = NBITS * CPB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_ser_if bus_a ();
  nibble_ser_if bus_b ();
  state_t st_a;
  state_t st_b;

  nibble_ser_tx #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(st_a)
  );

  nibble_ser_tx #(.CLKS_PER_BIT(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(st_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queue: per-cycle {ser_out, busy, done}.
  logic [2:0] exp_q[$];

  typedef struct {
    logic [3:0] data;
    logic [6:0] seq;   // [6]=start, [5:2]=data in wire order, [1]=parity, [0]=stop
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame from the rules: low start, data bits in order, even parity, high stop.
  function automatic logic [6:0] model_seq(input logic [3:0] d, input bit msb_first);
    logic [6:0] s;
    s[6] = 1'b0;
    for (int i = 0; i < 4; i++) s[5-i] = msb_first ? d[3-i] : d[i];
    s[1] = ^d;
    s[0] = 1'b1;
    return s;
  endfunction

  function automatic logic bit_at(input logic [6:0] s, input int k);
    return (k == NBITS - 1) ? s[0] : s[6-k];
  endfunction

  task automatic wait_ready_a(input string name);
    int n = 0;
    while (!bus_a.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready"}, 32'(bus_a.in_ready), 32'd1);
  endtask

  // Called at a negedge; leaves the bench at the negedge of the idle cycle after the frame.
  task automatic send_a(input logic [3:0] d, input logic [6:0] s, input string name,
                        input bit hold, input logic [3:0] d_after);
    logic [2:0] e;
    wait_ready_a(name);
    exp_q.delete();
    for (int c = 0; c < FLEN; c++)
      exp_q.push_back({bit_at(s, c / CPB), 1'b1, (c == FLEN - 1)});
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    @(posedge clk);
    for (int c = 0; c < FLEN; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus_a.in_valid = hold;
        bus_a.in_data  = d_after;
      end
      e = exp_q.pop_front();
      chk($sformatf("%s_ser_c%0d", name, c),   32'(bus_a.ser_out),  32'(e[2]));
      chk($sformatf("%s_busy_c%0d", name, c),  32'(bus_a.busy),     32'(e[1]));
      chk($sformatf("%s_done_c%0d", name, c),  32'(bus_a.done),     32'(e[0]));
      chk($sformatf("%s_ready_c%0d", name, c), 32'(bus_a.in_ready), 32'd0);
    end
    @(negedge clk);
    chk({name, "_gap_busy"},  32'(bus_a.busy),     32'd0);
    chk({name, "_gap_ready"}, 32'(bus_a.in_ready), 32'd1);
    chk({name, "_gap_ser"},   32'(bus_a.ser_out),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[8];
    logic [6:0] bexp;
    logic [3:0] d;
    bit         seen_done;

    tbl[0] = '{4'hA, 7'b0101001};
    tbl[1] = '{4'hC, 7'b0110001};
    tbl[2] = '{4'hF, 7'b0111101};
    tbl[3] = '{4'h7, 7'b0011111};
    tbl[4] = '{4'h0, 7'b0000001};
    tbl[5] = '{4'h5, 7'b0010101};
    tbl[6] = '{4'h1, 7'b0000111};
    tbl[7] = '{4'h2, 7'b0001011};

    // ---------------- reset ----------------
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = 4'h0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_ser",   32'(bus_a.ser_out),  32'd1);
    chk("rst_busy",  32'(bus_a.busy),     32'd0);
    chk("rst_done",  32'(bus_a.done),     32'd0);
    chk("rst_ready", 32'(bus_a.in_ready), 32'd0);
    chk("rst_state", 32'(st_a),           32'(IDLE));
    chk("rst_b_ser", 32'(bus_b.ser_out),  32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready",   32'(bus_a.in_ready), 32'd1);
    chk("post_rst_b_ready", 32'(bus_b.in_ready), 32'd1);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 8; i++)
      send_a(tbl[i].data, tbl[i].seq, $sformatf("tbl%0d", i), 1'b0, 4'h0);

    // ---------------- back-to-back with in_valid held ----------------
    send_a(4'hC, tbl[1].seq, "b2b_first", 1'b1, 4'hF);
    send_a(4'hF, tbl[2].seq, "b2b_second", 1'b0, 4'h0);

    // ---------------- in_data changed right after capture ----------------
    send_a(4'hC, tbl[1].seq, "late_change", 1'b0, 4'h2);

    // ---------------- reset during 2nd data bit ----------------
    wait_ready_a("rst_mid");
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'hA;
    @(posedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    for (int c = 1; c <= 2 * CPB + 1; c++) @(negedge clk);
    chk("rst_mid_in_data", 32'(st_a), 32'(DATA));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ser",   32'(bus_a.ser_out),  32'd1);
    chk("rst_mid_busy",  32'(bus_a.busy),     32'd0);
    chk("rst_mid_done",  32'(bus_a.done),     32'd0);
    chk("rst_mid_ready", 32'(bus_a.in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_after", 32'(bus_a.in_ready), 32'd1);
    seen_done = 1'b0;
    for (int c = 0; c < FLEN + 4; c++) begin
      if (bus_a.done || bus_a.busy) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("rst_mid_no_done", 32'(seen_done), 32'd0);

    // ---------------- reset wins over a simultaneous handshake ----------------
    rst = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.in_data = 4'h5;
    @(negedge clk);
    chk("rst_prio_busy",  32'(bus_a.busy), 32'd0);
    chk("rst_prio_state", 32'(st_a),       32'(IDLE));
    rst = 1'b0;
    bus_a.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_prio_idle", 32'(bus_a.busy), 32'd0);

    // ---------------- one cycle per bit, LSB first ----------------
`ifdef NIBBLE_SER_PARITY_EN
    bexp = 7'b0100011;
`else
    bexp = 7'b0010001;
`endif
    bus_b.in_valid = 1'b1; bus_b.in_data = 4'h1;
    @(posedge clk);
    for (int c = 0; c < NBITS; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = 4'hE;
      end
      chk($sformatf("cpb1_ser_c%0d", c),  32'(bus_b.ser_out), 32'(bexp[NBITS-1-c]));
      chk($sformatf("cpb1_busy_c%0d", c), 32'(bus_b.busy),    32'd1);
      chk($sformatf("cpb1_done_c%0d", c), 32'(bus_b.done),    32'(c == NBITS - 1));
    end
    @(negedge clk);
    chk("cpb1_idle_busy",  32'(bus_b.busy),     32'd0);
    chk("cpb1_idle_ready", 32'(bus_b.in_ready), 32'd1);

    // ---------------- random nibbles against the model ----------------
    for (int i = 0; i < 20; i++) begin
      d = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_a(d, model_seq(d, 1'b1), $sformatf("rand%0d", i), 1'b0, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
